// File: rtl/hdmi_frame_sequencer_pkg.sv
// Shared types and default widths for the HDMI frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a; the video path is free-running with no stall.
package hdmi_seq_pkg;

  localparam int DEF_X_W = 12;
  localparam int DEF_Y_W = 11;

  // Timing-lock sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    VERIFY  = 2'd2,
    LOCKED  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/hdmi_frame_sequencer_timing_cnt.sv
// Video timing front end: 1-cycle delay of de/hsync/vsync, pixel/line counters,
// vsync-edge and de-fall detection, and pixel coordinates.
// Latency: de_o/hsync_o/vsync_o/x_o/y_o/strobes are 1 pclk after the inputs.
// Backpressure: none; the input stream cannot be stalled.
// Ports: pclk/rstbtn_n clock and reset; de_i/hsync_i/vsync_i raw video;
//   de_o/hsync_o/vsync_o delayed video; x_o/y_o coordinates; line_start_o/frame_start_o strobes;
//   vs_edge_o/de_fall_o same-cycle events on the inputs; pix_cnt_o/line_cnt_o and their
//   saturation flags for the measurement logic.
module video_timing_cnt
  import hdmi_seq_pkg::*;
#(
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int VS_POL = 1
) (
  input  logic           pclk,
  input  logic           rstbtn_n,
  input  logic           de_i,
  input  logic           hsync_i,
  input  logic           vsync_i,
  output logic           de_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           line_start_o,
  output logic           frame_start_o,
  output logic           vs_edge_o,
  output logic           de_fall_o,
  output logic [X_W-1:0] pix_cnt_o,
  output logic [Y_W-1:0] line_cnt_o,
  output logic           pix_sat_o,
  output logic           line_sat_o
);

  logic           de_q, hs_q, vs_q, vs_act_q;
  logic           ls_q, fs_q;
  logic [X_W-1:0] pix_cnt, pix_nxt, x_q;
  logic [Y_W-1:0] line_cnt, line_nxt, y_q;
  logic           vs_act, vs_edge, de_fall, de_rise;
  logic           pix_sat, line_sat;

  assign vs_act   = (VS_POL != 0) ? vsync_i : ~vsync_i;
  assign vs_edge  = vs_act & ~vs_act_q;
  assign de_fall  = ~de_i & de_q;
  assign de_rise  = de_i & ~de_q;
  assign pix_sat  = &pix_cnt;
  assign line_sat = &line_cnt;

  // pix_cnt holds the 0-based column of the pixel currently in the delay
  // register, so at de_fall it is (line length - 1).
  always_comb begin
    pix_nxt = pix_cnt;
    if (de_fall)
      pix_nxt = '0;
    else if (de_i && de_q && !pix_sat)
      pix_nxt = pix_cnt + 1'b1;
  end

  always_comb begin
    line_nxt = line_cnt;
    if (vs_edge)
      line_nxt = '0;
    else if (de_fall && !line_sat)
      line_nxt = line_cnt + 1'b1;
  end

  always_ff @(posedge pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      de_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      vs_act_q <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      de_q     <= de_i;
      hs_q     <= hsync_i;
      vs_q     <= vsync_i;
      vs_act_q <= vs_act;
      ls_q     <= de_rise;
      fs_q     <= vs_edge;
      pix_cnt  <= pix_nxt;
      line_cnt <= line_nxt;
      // Coordinates only move with active pixels; blanking keeps the last value
      // until the frame start clears them.
      if (vs_edge) begin
        x_q <= '0;
        y_q <= '0;
      end else if (de_i) begin
        x_q <= pix_nxt;
        y_q <= line_cnt;
      end
    end
  end

  assign de_o          = de_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign x_o           = x_q;
  assign y_o           = y_q;
  assign line_start_o  = ls_q;
  assign frame_start_o = fs_q;
  assign vs_edge_o     = vs_edge;
  assign de_fall_o     = de_fall;
  assign pix_cnt_o     = pix_cnt;
  assign line_cnt_o    = line_cnt;
  assign pix_sat_o     = pix_sat;
  assign line_sat_o    = line_sat;

endmodule

// File: rtl/hdmi_frame_sequencer.sv
// Locks onto incoming video timing and sequences the filter/bypass select on frame boundaries.
// Latency: all outputs registered, aligned 1 pclk after the decoder inputs.
// Backpressure: none; filt_req_i is sampled only at frame start while locked.
// Ports: pclk/rstbtn_n clock and reset; de_i/hsync_i/vsync_i/filt_req_i inputs;
//   de_o/hsync_o/vsync_o/x_o/y_o/line_start_o/frame_start_o delayed video and strobes;
//   locked_o/path_sel_o/h_active_o/v_active_o/lock_err_o lock status and path select.
module hdmi_frame_sequencer
  import hdmi_seq_pkg::*;
#(
  parameter int X_W         = DEF_X_W,
  parameter int Y_W         = DEF_Y_W,
  parameter int LOCK_FRAMES = 3,
  parameter int VS_POL      = 1
) (
  input  logic           pclk,
  input  logic           rstbtn_n,
  input  logic           de_i,
  input  logic           hsync_i,
  input  logic           vsync_i,
  input  logic           filt_req_i,
  output logic           de_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           line_start_o,
  output logic           frame_start_o,
  output logic           locked_o,
  output logic           path_sel_o,
  output logic [X_W-1:0] h_active_o,
  output logic [Y_W-1:0] v_active_o,
  output logic           lock_err_o
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  logic           vs_edge, de_fall, pix_sat, line_sat;
  logic [X_W-1:0] pix_cnt;
  logic [Y_W-1:0] line_cnt;

  video_timing_cnt #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .VS_POL(VS_POL)
  ) u_cnt (
    .pclk         (pclk),
    .rstbtn_n     (rstbtn_n),
    .de_i         (de_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .de_o         (de_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .x_o          (x_o),
    .y_o          (y_o),
    .line_start_o (line_start_o),
    .frame_start_o(frame_start_o),
    .vs_edge_o    (vs_edge),
    .de_fall_o    (de_fall),
    .pix_cnt_o    (pix_cnt),
    .line_cnt_o   (line_cnt),
    .pix_sat_o    (pix_sat),
    .line_sat_o   (line_sat)
  );

  seq_state_t     state_q, state_d;
  logic [X_W-1:0] h_active_q, h_active_d;
  logic [Y_W-1:0] v_active_q, v_active_d;
  logic [3:0]     match_q, match_d, match_inc;
  logic           armed_q, armed_d;   // a measurement window has opened at a vsync edge
  logic           h_got_q, h_got_d;   // line length captured for the current measurement
  logic           path_q, path_d;
  logic           err_q, err_d;
  logic           len_bad, lines_bad, mismatch;

  // A saturated counter can never equal a sane measured value, so it is
  // folded into the mismatch directly.
  assign len_bad   = pix_sat  || (pix_cnt != h_active_q - 1'b1);
  assign lines_bad = line_sat || (line_cnt != v_active_q);
  // A bad line and a bad frame in the same cycle collapse into one event.
  assign mismatch  = (de_fall && len_bad) || (vs_edge && lines_bad);
  assign match_inc = match_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    h_active_d = h_active_q;
    v_active_d = v_active_q;
    match_d    = match_q;
    armed_d    = armed_q;
    h_got_d    = h_got_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (vs_edge) begin
          state_d = MEASURE;
          armed_d = 1'b1;
          h_got_d = 1'b0;
        end
      end
      MEASURE: begin
        if (vs_edge) begin
          if (armed_q && h_got_q && (line_cnt != '0) && !line_sat) begin
            v_active_d = line_cnt;
            match_d    = 4'd0;
            state_d    = VERIFY;
          end else begin
            // No usable frame yet: restart the window at this edge.
            armed_d = 1'b1;
            h_got_d = 1'b0;
          end
        end else if (de_fall && armed_q && !h_got_q && !pix_sat) begin
          h_active_d = pix_cnt + 1'b1;
          h_got_d    = 1'b1;
        end
      end
      VERIFY: begin
        if (mismatch) begin
          state_d = MEASURE;
          armed_d = vs_edge;  // mid-frame loss waits for the next vsync edge
          h_got_d = 1'b0;
        end else if (vs_edge) begin
          if (match_inc == LOCK_N)
            state_d = LOCKED;
          match_d = match_inc;
        end
      end
      LOCKED: begin
        if (mismatch) begin
          state_d = MEASURE;
          armed_d = vs_edge;
          h_got_d = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select only follows the request at a frame start while locked; losing lock
  // drops to bypass at once.
  always_comb begin
    path_d = path_q;
    if (state_d != LOCKED)
      path_d = 1'b0;
    else if (vs_edge)
      path_d = filt_req_i;
  end

  always_ff @(posedge pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state_q    <= IDLE;
      h_active_q <= '0;
      v_active_q <= '0;
      match_q    <= 4'd0;
      armed_q    <= 1'b0;
      h_got_q    <= 1'b0;
      path_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_active_q <= h_active_d;
      v_active_q <= v_active_d;
      match_q    <= match_d;
      armed_q    <= armed_d;
      h_got_q    <= h_got_d;
      path_q     <= path_d;
      err_q      <= err_d;
    end
  end

  assign locked_o   = (state_q == LOCKED);
  assign path_sel_o = path_q;
  assign h_active_o = h_active_q;
  assign v_active_o = v_active_q;
  assign lock_err_o = err_q;

endmodule

// File: tb/tb_hdmi_frame_sequencer.sv
// Directed bench for hdmi_frame_sequencer: vector table for pipeline/coords,
// then hand sequences for lock, path switching, lock loss, reset and no-video.
// Latency: outputs are checked 1 ns after the edge that registered the inputs.
module tb_hdmi_frame_sequencer;

  logic        pclk = 1'b0;
  logic        rstbtn_n = 1'b0;
  logic        de_i = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0, filt_req_i = 1'b0;
  logic        de_o, hsync_o, vsync_o, line_start_o, frame_start_o;
  logic        locked_o, path_sel_o, lock_err_o;
  logic [11:0] x_o, h_active_o;
  logic [10:0] y_o, v_active_o;

  always #5 pclk = ~pclk;

  hdmi_frame_sequencer dut (
    .pclk         (pclk),
    .rstbtn_n     (rstbtn_n),
    .de_i         (de_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .filt_req_i   (filt_req_i),
    .de_o         (de_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .x_o          (x_o),
    .y_o          (y_o),
    .line_start_o (line_start_o),
    .frame_start_o(frame_start_o),
    .locked_o     (locked_o),
    .path_sel_o   (path_sel_o),
    .h_active_o   (h_active_o),
    .v_active_o   (v_active_o),
    .lock_err_o   (lock_err_o)
  );

  int checks = 0;
  int errors = 0;

  // Per-frame observations gathered by send_frame
  logic lk_at_vs, ps_at_vs, ps_end;
  logic lk_pre_err, err_at, lk_at_err, ps_at_err, err_next;
  int   ls_pulses, err_pulses;

  typedef struct {
    logic de, hs, vs;
    logic e_de, e_hs, e_vs, e_fs, e_ls;
    int   e_x, e_y;
  } vec_t;
  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic de, input logic hs, input logic vs);
    de_i    = de;
    hsync_i = hs;
    vsync_i = vs;
    @(posedge pclk);
    #1;
    if (line_start_o) ls_pulses++;
    if (lock_err_o) err_pulses++;
  endtask

  task automatic do_reset();
    de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    rstbtn_n = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    rstbtn_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  // One frame: 2 vsync cycles, porch, v lines of h pixels (bad_line is one
  // pixel short), 3 blanking cycles per line. filt_req_i rises at filt_line.
  task automatic send_frame(input int h, input int v, input int bad_line,
                            input int filt_line, input bit chk);
    int n;
    ls_pulses  = 0;
    err_pulses = 0;
    cyc(1'b0, 1'b0, 1'b1);
    lk_at_vs = locked_o;
    ps_at_vs = path_sel_o;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int l = 0; l < v; l++) begin
      if (l == filt_line) filt_req_i = 1'b1;
      n = (l == bad_line) ? h - 1 : h;
      for (int p = 0; p < n; p++) begin
        cyc(1'b1, 1'b0, 1'b0);
        if (chk)
          check("coord", {60'(0), de_o, line_start_o, 1'b0, 1'b0} | (64'(x_o) << 4) | (64'(y_o) << 16),
                {60'(0), 1'b1, (p == 0), 1'b0, 1'b0} | (64'(p) << 4) | (64'(l) << 16));
      end
      if (l == bad_line) lk_pre_err = locked_o;
      cyc(1'b0, 1'b1, 1'b0);
      if (l == bad_line) begin
        err_at    = lock_err_o;
        lk_at_err = locked_o;
        ps_at_err = path_sel_o;
      end
      cyc(1'b0, 1'b0, 1'b0);
      if (l == bad_line) err_next = lock_err_o;
      cyc(1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    ps_end = path_sel_o;
  endtask

  function automatic logic [53:0] all_outs();
    return {de_o, hsync_o, vsync_o, line_start_o, frame_start_o, locked_o, path_sel_o,
            lock_err_o, x_o, y_o, h_active_o, v_active_o};
  endfunction

  initial begin
    // pipeline/coordinate vectors: {de,hs,vs} -> {de_o,hs_o,vs_o,fs,ls,x,y}
    vecs[0]  = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0, 0,0};
    vecs[1]  = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0, 0,0};
    vecs[2]  = '{1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0, 0,0};
    vecs[3]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1, 0,0};
    vecs[4]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1,0};
    vecs[5]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0, 2,0};
    vecs[6]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2,0};
    vecs[7]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 2,0};
    vecs[8]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1, 0,1};
    vecs[9]  = '{1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0, 1,1};
    vecs[10] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1,1};
    vecs[11] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1,1'b0, 0,0};
    vecs[12] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0, 0,0};

    // reset state
    repeat (2) @(posedge pclk);
    #1;
    check("reset_outs", 64'(all_outs()), 64'(0));
    rstbtn_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // vector table
    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].de, vecs[i].hs, vecs[i].vs);
      check($sformatf("vec%0d", i),
            {30'(0), de_o, hsync_o, vsync_o, frame_start_o, line_start_o, 12'(x_o), 11'(y_o), 3'(0)},
            {30'(0), vecs[i].e_de, vecs[i].e_hs, vecs[i].e_vs, vecs[i].e_fs, vecs[i].e_ls,
             12'(vecs[i].e_x), 11'(vecs[i].e_y), 3'(0)});
    end

    // lock on 8x4: locked at the 5th vsync edge
    do_reset();
    for (int f = 0; f < 4; f++) send_frame(8, 4, -1, -1, 1'b0);
    check("lock_not_at_vs4", 64'(lk_at_vs), 64'(0));
    send_frame(8, 4, -1, -1, 1'b1);
    check("lock_at_vs5", 64'(lk_at_vs), 64'(1));
    check("h_active", 64'(h_active_o), 64'(8));
    check("v_active", 64'(v_active_o), 64'(4));
    check("line_starts", 64'(ls_pulses), 64'(4));
    check("path_bypass", 64'(ps_at_vs), 64'(0));

    // filter request mid-frame takes effect only at the next vsync edge
    send_frame(8, 4, -1, 2, 1'b0);
    check("path_hold_midframe", 64'(ps_end), 64'(0));
    send_frame(8, 4, -1, -1, 1'b1);
    check("path_at_vs", 64'(ps_at_vs), 64'(1));
    check("still_locked", 64'(locked_o), 64'(1));

    // lock loss on a 7-pixel line
    send_frame(8, 4, 1, -1, 1'b0);
    check("loss_pre_locked", 64'(lk_pre_err), 64'(1));
    check("loss_err_pulse", 64'(err_at), 64'(1));
    check("loss_unlocked", 64'(lk_at_err), 64'(0));
    check("loss_bypass", 64'(ps_at_err), 64'(0));
    check("loss_err_1cyc", 64'(err_next), 64'(0));
    check("loss_err_count", 64'(err_pulses), 64'(1));
    check("loss_frame_bypass", 64'(ps_end), 64'(0));
    for (int f = 0; f < 4; f++) send_frame(8, 4, -1, -1, 1'b0);
    check("relock_not_yet", 64'(lk_at_vs), 64'(0));
    send_frame(8, 4, -1, -1, 1'b0);
    check("relock", 64'(lk_at_vs), 64'(1));
    check("relock_path", 64'(ps_at_vs), 64'(1));

    // asynchronous reset mid-line while locked with filter selected
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    rstbtn_n = 1'b0;
    #1;
    check("async_reset_outs", 64'(all_outs()), 64'(0));
    repeat (2) @(posedge pclk);
    #1;
    check("held_reset_outs", 64'(all_outs()), 64'(0));
    de_i = 1'b0;
    rstbtn_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 4; f++) send_frame(8, 4, -1, -1, 1'b0);
    check("post_reset_not_locked", 64'(lk_at_vs), 64'(0));
    send_frame(8, 4, -1, -1, 1'b0);
    check("post_reset_relock", 64'(lk_at_vs), 64'(1));

    // vsync with no active video never locks
    do_reset();
    for (int f = 0; f < 6; f++) send_frame(8, 0, -1, -1, 1'b0);
    check("novideo_locked", 64'(locked_o), 64'(0));
    check("novideo_path", 64'(path_sel_o), 64'(0));
    check("novideo_active", 64'({h_active_o, v_active_o}), 64'(0));
    check("novideo_err", 64'(err_pulses), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
